ddr4_v2_2_20_axi_rr_arbiter: RTL and testbench

//  Round-robin arbiter + payload mux sharing one AXI-style downstream channel among C_NUM_REQ

---
 rtl/ddr4_v2_2_20_axi_arb_pkg.sv | 20 ++
 rtl/ddr4_v2_2_20_carry_latch_or.sv | 15 +
 rtl/ddr4_v2_2_20_rr_pick.sv | 19 +
 rtl/ddr4_v2_2_20_axi_rr_arbiter.sv | 76 +++++++
 tb/tb_ddr4_v2_2_20_axi_rr_arbiter.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/ddr4_v2_2_20_axi_arb_pkg.sv
// ddr4_v2_2_20_axi_arb_pkg: shared types and round-robin winner function for the AXI arbiter
package ddr4_v2_2_20_axi_arb_pkg;
  localparam int C_MAX_REQ = 16;
  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;
  function automatic logic [3:0] rr_next(input logic [C_MAX_REQ-1:0] valid, input logic [3:0] ptr, input int n);
    logic [3:0] r;
    logic f;
    int j;
    r = '0;
    f = 1'b0;
    for (int k = 1; k <= C_MAX_REQ; k++) begin
      j = (int'(ptr) + k) % n;
      if (k <= n && !f && valid[j[3:0]]) begin
        r = j[3:0];
        f = 1'b1;
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/ddr4_v2_2_20_carry_latch_or.sv
// ddr4_v2_2_20_carry_latch_or: one link of the carry-chain OR used for any-request detection
module ddr4_v2_2_20_carry_latch_or #(
  parameter C_FAMILY = "virtex6"
) (
  input  logic CIN,
  input  logic I,
  output logic O
);
  // Primitive-mapped families and plain RTL both reduce to an OR behaviourally.
  if (C_FAMILY == "rtl") begin : g_rtl
    assign O = CIN | I;
  end else begin : g_prim
    assign O = I | CIN;
  end
endmodule

// File: rtl/ddr4_v2_2_20_rr_pick.sv
// ddr4_v2_2_20_rr_pick: combinational rotate-priority picker starting after the last winner
module ddr4_v2_2_20_rr_pick
  import ddr4_v2_2_20_axi_arb_pkg::*;
#(
  parameter int C_NUM_REQ   = 4,
  parameter int C_IDX_WIDTH = 2
) (
  input  logic [C_NUM_REQ-1:0]   valid,
  input  logic [C_IDX_WIDTH-1:0] ptr,
  output logic [C_NUM_REQ-1:0]   grant,
  output logic [C_IDX_WIDTH-1:0] idx,
  output logic                   any
);
  always_comb begin
    idx   = C_IDX_WIDTH'(rr_next(C_MAX_REQ'(valid), 4'(ptr), C_NUM_REQ));
    any   = |valid;
    grant = any ? C_NUM_REQ'(1) << idx : '0;
  end
endmodule

// File: rtl/ddr4_v2_2_20_axi_rr_arbiter.sv
// ddr4_v2_2_20_axi_rr_arbiter: burst-holding round-robin arbiter and payload mux onto one AXI channel
module ddr4_v2_2_20_axi_rr_arbiter
  import ddr4_v2_2_20_axi_arb_pkg::*;
#(
  parameter C_FAMILY            = "virtex6",
  parameter int C_NUM_REQ       = 4,
  parameter int C_PAYLOAD_WIDTH = 64,
  localparam int C_IDX_WIDTH    = (C_NUM_REQ > 2) ? $clog2(C_NUM_REQ) : 1
) (
  input  logic                                 ACLK,
  input  logic                                 ARESET,
  input  logic [C_NUM_REQ-1:0]                 S_VALID,
  input  logic [C_NUM_REQ-1:0]                 S_LAST,
  input  logic [C_NUM_REQ*C_PAYLOAD_WIDTH-1:0] S_PAYLOAD,
  output logic [C_NUM_REQ-1:0]                 S_READY,
  output logic                                 M_VALID,
  output logic                                 M_LAST,
  output logic [C_PAYLOAD_WIDTH-1:0]           M_PAYLOAD,
  output logic [C_IDX_WIDTH-1:0]               M_SEL,
  input  logic                                 M_READY
);
  arb_state_t state, state_nx;
  logic [C_IDX_WIDTH-1:0] ptr, sel, pick_idx;
  logic [C_NUM_REQ-1:0] grant_q, pick_grant, carry;
  logic pick_any, any_valid, hs, in_grant;
  logic [C_PAYLOAD_WIDTH-1:0] pay [C_NUM_REQ];
  assign carry[0] = S_VALID[0];
  for (genvar i = 1; i < C_NUM_REQ; i++) begin : g_or
    ddr4_v2_2_20_carry_latch_or #(.C_FAMILY(C_FAMILY)) u_or (
      .CIN(carry[i-1]),
      .I  (S_VALID[i]),
      .O  (carry[i])
    );
  end
  assign any_valid = carry[C_NUM_REQ-1];
  for (genvar i = 0; i < C_NUM_REQ; i++) begin : g_pay
    assign pay[i] = S_PAYLOAD[i*C_PAYLOAD_WIDTH +: C_PAYLOAD_WIDTH];
  end
  ddr4_v2_2_20_rr_pick #(
    .C_NUM_REQ  (C_NUM_REQ),
    .C_IDX_WIDTH(C_IDX_WIDTH)
  ) u_pick (
    .valid(S_VALID),
    .ptr  (ptr),
    .grant(pick_grant),
    .idx  (pick_idx),
    .any  (pick_any)
  );
  always_comb begin
    in_grant  = state == ARB_GRANT;
    M_VALID   = in_grant & S_VALID[sel];
    M_LAST    = in_grant & S_LAST[sel];
    M_PAYLOAD = pay[sel];
    M_SEL     = sel;
    S_READY   = (in_grant & M_READY) ? grant_q : '0;
    hs        = M_VALID & M_READY;
    state_nx  = in_grant ? ((hs & M_LAST) ? ARB_IDLE : ARB_GRANT)
                         : ((any_valid & pick_any) ? ARB_GRANT : ARB_IDLE);
  end
  // Grant is captured only on IDLE->GRANT; the pointer moves only when a burst completes.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state   <= ARB_IDLE;
      ptr     <= C_IDX_WIDTH'(C_NUM_REQ - 1);
      sel     <= '0;
      grant_q <= '0;
    end else begin
      state <= state_nx;
      if (!in_grant && state_nx == ARB_GRANT) begin
        grant_q <= pick_grant;
        sel     <= pick_idx;
      end
      if (in_grant && state_nx == ARB_IDLE) ptr <= sel;
    end
  end
endmodule

// File: tb/tb_ddr4_v2_2_20_axi_rr_arbiter.sv
// tb_ddr4_v2_2_20_axi_rr_arbiter: directed scenarios plus randomized traffic against a round-robin model
module tb_ddr4_v2_2_20_axi_rr_arbiter;
  localparam int N = 4;
  localparam int W = 16;
  logic clk = 1'b0;
  logic rst, mr, mv, ml;
  logic [N-1:0] sv, sl, sr;
  logic [W-1:0] pay [N];
  logic [N*W-1:0] sp;
  logic [W-1:0] mp;
  logic [1:0] msel;
  int checks = 0;
  int errors = 0;
  bit m_busy;
  int m_owner, m_last;
  assign sp = {pay[3], pay[2], pay[1], pay[0]};
  always #5 clk = ~clk;
  ddr4_v2_2_20_axi_rr_arbiter #(.C_FAMILY("virtex6"), .C_NUM_REQ(N), .C_PAYLOAD_WIDTH(W)) dut (
    .ACLK(clk), .ARESET(rst), .S_VALID(sv), .S_LAST(sl), .S_PAYLOAD(sp), .S_READY(sr),
    .M_VALID(mv), .M_LAST(ml), .M_PAYLOAD(mp), .M_SEL(msel), .M_READY(mr)
  );
  task automatic adv();
    int j;
    @(posedge clk);
    if (rst) begin
      m_busy = 0; m_owner = 0; m_last = N - 1;
    end else if (!m_busy) begin
      for (int k = 1; k <= N; k++) begin
        j = (m_last + k) % N;
        if (!m_busy && sv[j]) begin m_owner = j; m_busy = 1; end
      end
    end else if (sv[m_owner] && mr && sl[m_owner]) begin
      m_last = m_owner; m_busy = 0;
    end
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1; sv = '0; sl = '0; mr = 1'b1;
    adv();
    rst = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1; sv = 4'b1111; sl = 4'b1111; mr = 1'b1;
    @(negedge clk);
    checks += 3;
    if (mv !== 1'b0) begin errors++; $display("FAIL reset_mvalid got %b exp 0", mv); end
    if (sr !== 4'b0) begin errors++; $display("FAIL reset_sready got %b exp 0000", sr); end
    if (msel !== 2'd0) begin errors++; $display("FAIL reset_msel got %0d exp 0", msel); end
    adv();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (mv !== 1'b0) begin errors++; $display("FAIL release_idle got %b exp 0", mv); end
    adv();
    @(negedge clk);
    checks += 2;
    if (mv !== 1'b1) begin errors++; $display("FAIL release_mvalid got %b exp 1", mv); end
    if (msel !== 2'd0) begin errors++; $display("FAIL release_msel got %0d exp 0", msel); end
    adv();
  endtask
  task automatic test_rotation();
    do_reset();
    sv = 4'b1111; sl = 4'b1111; mr = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (mv !== 1'(k % 2)) begin errors++; $display("FAIL rot_valid[%0d] got %b exp %b", k, mv, k % 2); end
      if (k % 2 == 1) begin
        checks += 2;
        if (msel !== 2'((k / 2) % N)) begin errors++; $display("FAIL rot_sel[%0d] got %0d exp %0d", k, msel, (k / 2) % N); end
        if (sr !== 4'(1 << ((k / 2) % N))) begin errors++; $display("FAIL rot_ready[%0d] got %b exp %b", k, sr, 4'(1 << ((k / 2) % N))); end
      end
      adv();
    end
  endtask
  task automatic test_burst_hold();
    do_reset();
    sv = 4'b0110; sl = 4'b0100; mr = 1'b1; pay[2] = 16'h2222;
    @(negedge clk);
    checks++;
    if (mv !== 1'b0) begin errors++; $display("FAIL burst_idle0 got %b exp 0", mv); end
    adv();
    for (int b = 1; b <= 4; b++) begin
      sl[1] = (b == 4); pay[1] = 16'(16'h1000 + b);
      @(negedge clk);
      checks += 5;
      if (msel !== 2'd1) begin errors++; $display("FAIL burst_sel[%0d] got %0d exp 1", b, msel); end
      if (mv !== 1'b1) begin errors++; $display("FAIL burst_valid[%0d] got %b exp 1", b, mv); end
      if (sr !== 4'b0010) begin errors++; $display("FAIL burst_ready[%0d] got %b exp 0010", b, sr); end
      if (ml !== 1'(b == 4)) begin errors++; $display("FAIL burst_last[%0d] got %b exp %b", b, ml, b == 4); end
      if (mp !== pay[1]) begin errors++; $display("FAIL burst_pay[%0d] got %h exp %h", b, mp, pay[1]); end
      adv();
    end
    @(negedge clk);
    checks++;
    if (mv !== 1'b0) begin errors++; $display("FAIL burst_bubble got %b exp 0", mv); end
    adv();
    @(negedge clk);
    checks += 3;
    if (msel !== 2'd2) begin errors++; $display("FAIL burst_next_sel got %0d exp 2", msel); end
    if (mv !== 1'b1) begin errors++; $display("FAIL burst_next_valid got %b exp 1", mv); end
    if (mp !== 16'h2222) begin errors++; $display("FAIL burst_next_pay got %h exp 2222", mp); end
    adv();
    sv = '0;
    adv();
  endtask
  task automatic test_backpressure();
    do_reset();
    sv = 4'b0001; sl = 4'b0001; mr = 1'b0; pay[0] = 16'($urandom);
    adv();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks += 4;
      if (mv !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got %b exp 1", c, mv); end
      if (sr !== 4'b0) begin errors++; $display("FAIL bp_ready[%0d] got %b exp 0000", c, sr); end
      if (msel !== 2'd0) begin errors++; $display("FAIL bp_sel[%0d] got %0d exp 0", c, msel); end
      if (mp !== pay[0]) begin errors++; $display("FAIL bp_pay[%0d] got %h exp %h", c, mp, pay[0]); end
      adv();
    end
    mr = 1'b1;
    @(negedge clk);
    checks++;
    if (sr !== 4'b0001) begin errors++; $display("FAIL bp_release got %b exp 0001", sr); end
    adv();
    sv = '0;
    adv();
  endtask
  task automatic test_sparse_wrap();
    do_reset();
    sv = 4'b0100; sl = 4'b1111; mr = 1'b1;
    adv();
    @(negedge clk);
    checks++;
    if (msel !== 2'd2) begin errors++; $display("FAIL sparse_sel got %0d exp 2", msel); end
    adv();
    sv = 4'b0101;
    adv();
    @(negedge clk);
    checks += 2;
    if (msel !== 2'd0) begin errors++; $display("FAIL wrap_sel got %0d exp 0", msel); end
    if (mv !== 1'b1) begin errors++; $display("FAIL wrap_valid got %b exp 1", mv); end
    adv();
    sv = '0;
    adv();
  endtask
  task automatic test_reset_mid_burst();
    do_reset();
    sv = 4'b1000; sl = 4'b0000; mr = 1'b1; pay[3] = 16'habcd;
    adv();
    @(negedge clk);
    checks++;
    if (msel !== 2'd3) begin errors++; $display("FAIL mid_sel got %0d exp 3", msel); end
    adv();
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks += 2;
    if (mv !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b exp 0", mv); end
    if (sr !== 4'b0) begin errors++; $display("FAIL mid_rst_ready got %b exp 0000", sr); end
    adv();
    rst = 1'b0; sv = 4'b1111; sl = 4'b1111;
    adv();
    @(negedge clk);
    checks++;
    if (msel !== 2'd0) begin errors++; $display("FAIL mid_after_sel got %0d exp 0", msel); end
    adv();
    sv = '0;
    adv();
  endtask
  task automatic test_random();
    logic [N-1:0] e_ready;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      sv = 4'($urandom); sl = 4'($urandom); mr = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) pay[i] = 16'($urandom);
      @(negedge clk);
      e_ready = (m_busy && mr) ? 4'(1 << m_owner) : 4'b0;
      checks += 4;
      if (mv !== (m_busy && sv[m_owner])) begin errors++; $display("FAIL rnd_valid[%0d] got %b exp %b", c, mv, m_busy && sv[m_owner]); end
      if (ml !== (m_busy && sl[m_owner])) begin errors++; $display("FAIL rnd_last[%0d] got %b exp %b", c, ml, m_busy && sl[m_owner]); end
      if (sr !== e_ready) begin errors++; $display("FAIL rnd_ready[%0d] got %b exp %b", c, sr, e_ready); end
      if (msel !== 2'(m_owner)) begin errors++; $display("FAIL rnd_sel[%0d] got %0d exp %0d", c, msel, m_owner); end
      if (m_busy) begin
        checks++;
        if (mp !== pay[m_owner]) begin errors++; $display("FAIL rnd_pay[%0d] got %h exp %h", c, mp, pay[m_owner]); end
      end
      adv();
    end
  endtask
  initial begin
    rst = 1'b1; sv = '0; sl = '0; mr = 1'b0;
    for (int i = 0; i < N; i++) pay[i] = '0;
    m_busy = 0; m_owner = 0; m_last = N - 1;
    test_reset();
    test_rotation();
    test_burst_hold();
    test_backpressure();
    test_sparse_wrap();
    test_reset_mid_burst();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
